// File: rtl/multiport_regfile.sv
// Multiported register file: two combinational read ports, two write ports
// (single-cycle ALU writeback and long-latency writeback) and a per-entry busy
// scoreboard for outstanding long-latency destinations.
module multiport_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,

    // Read ports
    input  logic [ADDR_W-1:0] RADDR1,
    input  logic [ADDR_W-1:0] RADDR2,
    output logic [DATA_W-1:0] RDATA1,
    output logic [DATA_W-1:0] RDATA2,

    // Write port 0: single-cycle writeback
    input  logic              WEN0,
    input  logic [ADDR_W-1:0] WADDR0,
    input  logic [DATA_W-1:0] WDATA0,

    // Write port 1: long-latency writeback, retires the busy bit
    input  logic              WEN1,
    input  logic [ADDR_W-1:0] WADDR1,
    input  logic [DATA_W-1:0] WDATA1,

    // Scoreboard set for an issued long-latency destination
    input  logic              BSET_EN,
    input  logic [ADDR_W-1:0] BSET_ADDR,

    // Scoreboard status
    output logic              RBUSY1,
    output logic              RBUSY2,
    output logic [ADDR_W:0]   BUSY_CNT
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    // One-hot per-entry request vectors, already masked for the zero register
    logic [DEPTH-1:0]  wen0_dec;
    logic [DEPTH-1:0]  wen1_dec;
    logic [DEPTH-1:0]  bset_dec;

    // Same-cycle hits of the write ports against each read address
    logic              hit1_w0;
    logic              hit1_w1;
    logic              hit2_w0;
    logic              hit2_w1;

    // Decode write and busy-set addresses into per-entry enables
    always_comb begin
        wen0_dec = '0;
        wen1_dec = '0;
        bset_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG && i == 0)) begin
                wen0_dec[i] = WEN0    && (WADDR0    == ADDR_W'(i));
                wen1_dec[i] = WEN1    && (WADDR1    == ADDR_W'(i));
                bset_dec[i] = BSET_EN && (BSET_ADDR == ADDR_W'(i));
            end
        end
    end

    // Next data state: port 1 takes priority on a shared address
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wen1_dec[i]) begin
                mem_d[i] = WDATA1;
            end else if (wen0_dec[i]) begin
                mem_d[i] = WDATA0;
            end
        end
    end

    // Next busy state: a set in the same cycle as a clear keeps the entry busy
    always_comb begin
        busy_d = (busy_q & ~wen1_dec) | bset_d_mask(bset_dec);
    end

    // Identity helper keeps the set term readable alongside the clear mask
    function automatic logic [DEPTH-1:0] bset_d_mask(input logic [DEPTH-1:0] v);
        return v;
    endfunction

    // Busy count is the population count of the next busy vector
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    // State registers; synchronous active-low reset overrides every request
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Address-match detection for forwarding on both read ports
    always_comb begin
        hit1_w0 = BYPASS && WEN0 && (WADDR0 == RADDR1);
        hit1_w1 = BYPASS && WEN1 && (WADDR1 == RADDR1);
        hit2_w0 = BYPASS && WEN0 && (WADDR0 == RADDR2);
        hit2_w1 = BYPASS && WEN1 && (WADDR1 == RADDR2);
    end

    // Read port 1 data: reset and zero register force 0, then forwarding, then storage
    always_comb begin
        RDATA1 = '0;
        if (!RESET) begin
            RDATA1 = '0;
        end else if (ZERO_REG && RADDR1 == '0) begin
            RDATA1 = '0;
        end else if (hit1_w1) begin
            RDATA1 = WDATA1;
        end else if (hit1_w0) begin
            RDATA1 = WDATA0;
        end else begin
            RDATA1 = mem_q[RADDR1];
        end
    end

    // Read port 2 data: same priority as port 1
    always_comb begin
        RDATA2 = '0;
        if (!RESET) begin
            RDATA2 = '0;
        end else if (ZERO_REG && RADDR2 == '0) begin
            RDATA2 = '0;
        end else if (hit2_w1) begin
            RDATA2 = WDATA1;
        end else if (hit2_w0) begin
            RDATA2 = WDATA0;
        end else begin
            RDATA2 = mem_q[RADDR2];
        end
    end

    // Busy status: a retiring long-latency write hides the bit since its data is forwarded;
    // a set in this cycle only shows up from the next cycle
    always_comb begin
        RBUSY1 = 1'b0;
        RBUSY2 = 1'b0;
        if (RESET) begin
            RBUSY1 = busy_q[RADDR1] && !hit1_w1;
            RBUSY2 = busy_q[RADDR2] && !hit2_w1;
        end
    end

    // Registered count drives the output directly
    always_comb begin
        BUSY_CNT = busy_cnt_q;
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth SHALL be 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, SHALL, when 1, hardwire entry 0 to zero (reads 0, writes and busy-sets ignored).
REQ-004 Parameter BYPASS, default 1, SHALL, when 1, enable same-cycle write-to-read forwarding.
REQ-005 CLK  in  1  clock; all state SHALL update on the rising edge.
REQ-006 RESET  in  1  synchronous, active-low reset.
REQ-007 RADDR1, RADDR2  in  ADDR_W  read port addresses.
REQ-008 RDATA1, RDATA2  out  DATA_W  combinational read data.
REQ-009 WEN0, WADDR0, WDATA0  in  1/ADDR_W/DATA_W  write port 0 (single-cycle ALU writeback).
REQ-010 WEN1, WADDR1, WDATA1  in  1/ADDR_W/DATA_W  write port 1 (long-latency writeback; clears busy).
REQ-011 BSET_EN, BSET_ADDR  in  1/ADDR_W  scoreboard set request for an issued long-latency destination.
REQ-012 RBUSY1, RBUSY2  out  1  busy bit of entry RADDR1/RADDR2, including same-cycle set/clear effects per REQ-021.
REQ-013 BUSY_CNT  out  ADDR_W+1  registered count of currently busy entries.

Function
REQ-014 Storage SHALL be 2**ADDR_W x DATA_W flops plus one busy bit per entry.
REQ-015 WENn=1 SHALL write WDATAn to entry WADDRn at the rising edge; visible in storage from the next cycle.
REQ-016 Both ports writing the same address in one cycle: port 1 data SHALL be stored.
REQ-017 With ZERO_REG=1, writes to address 0 SHALL be dropped and RDATAx SHALL be 0 for address 0 regardless of bypass.
REQ-018 With BYPASS=1, RDATAx SHALL return WDATA1 if WEN1 and WADDR1==RADDRx, else WDATA0 if WEN0 and WADDR0==RADDRx, else the stored value; with BYPASS=0, stored value only.
REQ-019 BSET_EN=1 SHALL set busy[BSET_ADDR] at the rising edge; WEN1=1 SHALL clear busy[WADDR1] at the rising edge.
REQ-020 BSET and WEN1 on the same address in one cycle: set SHALL win (entry stays busy).
REQ-021 RBUSYx SHALL be combinational: stored busy bit, forced 0 when BYPASS=1 and WEN1 clears that address in the same cycle (data is being forwarded); BSET in the current cycle SHALL NOT affect RBUSYx until the next cycle.
REQ-022 WEN0 SHALL NOT change busy bits; a WEN0 to a busy entry SHALL update data but leave it busy.
REQ-023 BUSY_CNT SHALL equal the population count of busy bits after each edge (+1 per new set, -1 per effective clear, net 0 for set on an already-busy entry).
REQ-024 Busy set on address 0 with ZERO_REG=1 SHALL be ignored.

Reset
REQ-025 RESET=0 at a rising edge SHALL clear all entries and busy bits and BUSY_CNT to 0, overriding any write or set in that cycle.
REQ-026 While RESET=0, RDATA1/RDATA2 SHALL be 0 and RBUSY1/RBUSY2 SHALL be 0 combinationally.
REQ-027 Reset asserted mid-operation SHALL abandon all pending busy state; the first cycle after release SHALL accept writes and sets normally.

Verification
REQ-028 Reset: 2 cycles RESET=0, then read all 32 addresses -> all RDATA=0, BUSY_CNT=0.
REQ-029 Dual write: WEN0/WEN1 both to addr 7, WDATA0=0x11111111, WDATA1=0x22222222 -> same-cycle RDATA1(7)=0x22222222 (bypass), next cycle stored 0x22222222.
REQ-030 Zero register: WEN0 addr 0 data 0xDEADBEEF, BSET addr 0 -> RDATA1(0)=0 same and next cycle, BUSY_CNT=0.
REQ-031 Scoreboard: BSET addr 5 -> next cycle RBUSY1(5)=1, BUSY_CNT=1; WEN1 addr 5 data 0xA5A5A5A5 -> same cycle RBUSY1=0, RDATA1=0xA5A5A5A5; next cycle BUSY_CNT=0.
REQ-032 Set/clear collision: addr 9 busy, BSET and WEN1 both addr 9 -> next cycle busy[9]=1, BUSY_CNT unchanged, data updated.
REQ-033 Reset mid-operation: addrs 3,4 busy with data written, assert RESET=0 with concurrent WEN0 addr 3 -> next cycle all data 0, BUSY_CNT=0.
